// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: mode encodings, a complex sample struct,
// and the saturation helper used by the add/subtract core.
package fft_pkg;

   // Butterfly-leg selection for cplx_addsub_pipe
   localparam logic [1:0] MODE_ADD   = 2'b00;  // A + B
   localparam logic [1:0] MODE_SUB   = 2'b01;  // A - B
   localparam logic [1:0] MODE_SUB_J = 2'b10;  // A - jB
   localparam logic [1:0] MODE_ADD_J = 2'b11;  // A + jB

   // Default component width of a complex sample
   localparam int CPLX_W = 16;

   // Widest component width sat_clamp can produce
   localparam int SAT_MAX_W = 64;

   typedef struct packed {
      logic [CPLX_W-1:0] re;
      logic [CPLX_W-1:0] img;
   } cplx_t;

   // Largest positive (neg=0) or most negative (neg=1) w-bit two's-complement
   // value, returned in the low w bits; callers cast down to w bits.
   function automatic logic [SAT_MAX_W-1:0] sat_clamp(input logic neg, input int w);
      logic [SAT_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < SAT_MAX_W; i++) begin
         if (i == w - 1)
            r[i] = neg;
         else if (i < w - 1)
            r[i] = ~neg;
      end
      return r;
   endfunction

endpackage

// File: rtl/cplx_addsub_core.sv
// Combinational complex add/rotate at WIDTH+1 bits, then scale or wrap/saturate
// down to WIDTH bits. Saturation is enabled with the CPLX_ADDSUB_SAT_EN macro
// (only meaningful when SCALE=0); otherwise results wrap and ovf stays 0.
module cplx_addsub_core
   import fft_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SCALE = 0
) (
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a_re,
   input  logic [WIDTH-1:0] a_img,
   input  logic [WIDTH-1:0] b_re,
   input  logic [WIDTH-1:0] b_img,
   output logic [WIDTH-1:0] x_re,
   output logic [WIDTH-1:0] x_img,
   output logic             ovf
);

   logic [WIDTH:0] ar, ai, br, bi;
   logic [WIDTH:0] r_re, r_im;

   assign ar = {a_re[WIDTH-1], a_re};
   assign ai = {a_img[WIDTH-1], a_img};
   assign br = {b_re[WIDTH-1], b_re};
   assign bi = {b_img[WIDTH-1], b_img};

   // Full-precision butterfly leg; multiplying B by -j or +j swaps its components
   always_comb begin
      r_re = '0;
      r_im = '0;
      case (mode)
         MODE_ADD:   begin r_re = ar + br; r_im = ai + bi; end
         MODE_SUB:   begin r_re = ar - br; r_im = ai - bi; end
         MODE_SUB_J: begin r_re = ar + bi; r_im = ai - br; end
         MODE_ADD_J: begin r_re = ar - bi; r_im = ai + br; end
         default:    begin r_re = '0;      r_im = '0;      end
      endcase
   end

`ifdef CPLX_ADDSUB_SAT_EN
   logic ovf_re, ovf_im;
   assign ovf_re = r_re[WIDTH] ^ r_re[WIDTH-1];
   assign ovf_im = r_im[WIDTH] ^ r_im[WIDTH-1];
`endif

   // Reduce to WIDTH bits: halve (floor) when scaling, else wrap or clamp
   always_comb begin
      x_re  = r_re[WIDTH-1:0];
      x_img = r_im[WIDTH-1:0];
      ovf   = 1'b0;
      if (SCALE != 0) begin
         x_re  = r_re[WIDTH:1];
         x_img = r_im[WIDTH:1];
      end else begin
`ifdef CPLX_ADDSUB_SAT_EN
         if (ovf_re)
            x_re = WIDTH'(sat_clamp(r_re[WIDTH], WIDTH));
         if (ovf_im)
            x_img = WIDTH'(sat_clamp(r_im[WIDTH], WIDTH));
         ovf = ovf_re | ovf_im;
`endif
      end
   end

endmodule

// File: rtl/cplx_addsub_pipe.sv
// Two-stage pipelined complex add/subtract with valid/ready handshake.
// S1 registers operands, mode and tag; S2 registers the result and drives the
// outputs. Optional saturation and sticky ovf: CPLX_ADDSUB_SAT_EN.
module cplx_addsub_pipe
   import fft_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SCALE = 0,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a_re,
   input  logic [WIDTH-1:0] a_img,
   input  logic [WIDTH-1:0] b_re,
   input  logic [WIDTH-1:0] b_img,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x_re,
   output logic [WIDTH-1:0] x_img,
   output logic [TAG_W-1:0] tag_out,
   output logic             ovf
);

   logic             s1_valid, s2_valid;
   logic [1:0]       s1_mode;
   logic [WIDTH-1:0] s1_a_re, s1_a_img, s1_b_re, s1_b_img;
   logic [TAG_W-1:0] s1_tag;
   logic             adv1, adv2;
   logic [WIDTH-1:0] core_re, core_img;
   logic             core_ovf;
   logic             ovf_q;

   // Handshake: a stage advances when it is empty or its consumer takes its
   // contents this cycle. Input transfers on in_valid & in_ready, output on
   // out_valid & out_ready. in_ready is combinational from out_ready (no skid
   // buffer), which lets drain and accept happen in the same cycle bubble-free;
   // while stalled the S2 registers simply hold, keeping outputs stable.
   assign adv2      = !s2_valid || out_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid;
   assign ovf       = ovf_q;

   cplx_addsub_core #(
      .WIDTH (WIDTH),
      .SCALE (SCALE)
   ) u_core (
      .mode  (s1_mode),
      .a_re  (s1_a_re),
      .a_img (s1_a_img),
      .b_re  (s1_b_re),
      .b_img (s1_b_img),
      .x_re  (core_re),
      .x_img (core_img),
      .ovf   (core_ovf)
   );

   // S1 operand capture; payload needs no reset since s1_valid qualifies it
   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         s1_mode  <= mode;
         s1_a_re  <= a_re;
         s1_a_img <= a_img;
         s1_b_re  <= b_re;
         s1_b_img <= b_img;
         s1_tag   <= tag_in;
      end
   end

   // Stage valids, S2 result registers and sticky overflow (only real S2 loads count)
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         x_re     <= '0;
         x_img    <= '0;
         tag_out  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (adv1)
            s1_valid <= in_valid;
         if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               x_re    <= core_re;
               x_img   <= core_img;
               tag_out <= s1_tag;
               ovf_q   <= ovf_q | core_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_cplx_addsub_pipe.sv
// Directed bench for cplx_addsub_pipe: reset, mode/latency, backpressure,
// overflow wrap or saturation (follows CPLX_ADDSUB_SAT_EN), scaling via a
// second SCALE=1 instance, and reset while samples are in flight.
module tb_cplx_addsub_pipe;

   localparam int WIDTH = 16;
   localparam int TAG_W = 4;
   localparam int W     = TAG_W + 2 * WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, out_valid, out_ready, ovf;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a_re, a_img, b_re, b_img, x_re, x_img;
   logic [TAG_W-1:0] tag_in, tag_out;

   logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf;
   logic [1:0]       s_mode;
   logic [WIDTH-1:0] s_a_re, s_a_img, s_b_re, s_b_img, s_x_re, s_x_img;
   logic [TAG_W-1:0] s_tag_in, s_tag_out;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   cplx_addsub_pipe #(.WIDTH(WIDTH), .SCALE(0), .TAG_W(TAG_W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .a_re(a_re), .a_img(a_img), .b_re(b_re), .b_img(b_img),
      .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
      .x_re(x_re), .x_img(x_img), .tag_out(tag_out), .ovf(ovf)
   );

   cplx_addsub_pipe #(.WIDTH(WIDTH), .SCALE(1), .TAG_W(TAG_W)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .mode(s_mode), .a_re(s_a_re), .a_img(s_a_img), .b_re(s_b_re), .b_img(s_b_img),
      .tag_in(s_tag_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .x_re(s_x_re), .x_img(s_x_img), .tag_out(s_tag_out), .ovf(s_ovf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] m, input int ar, input int ai,
                        input int br, input int bi, input logic [TAG_W-1:0] t);
      in_valid = 1'b1;
      mode     = m;
      a_re     = ar[WIDTH-1:0];
      a_img    = ai[WIDTH-1:0];
      b_re     = br[WIDTH-1:0];
      b_img    = bi[WIDTH-1:0];
      tag_in   = t;
   endtask

   task automatic drive_s(input logic [1:0] m, input int ar, input int ai,
                          input int br, input int bi, input logic [TAG_W-1:0] t);
      s_in_valid = 1'b1;
      s_mode     = m;
      s_a_re     = ar[WIDTH-1:0];
      s_a_img    = ai[WIDTH-1:0];
      s_b_re     = br[WIDTH-1:0];
      s_b_img    = bi[WIDTH-1:0];
      s_tag_in   = t;
   endtask

   // Reference butterfly leg for small operands that never overflow
   function automatic logic [W-1:0] model(input int m, input int ar, input int ai,
                                          input int br, input int bi, input int t);
      int re, im;
      case (m)
         0:       begin re = ar + br; im = ai + bi; end
         1:       begin re = ar - br; im = ai - bi; end
         2:       begin re = ar + bi; im = ai - br; end
         default: begin re = ar - bi; im = ai + br; end
      endcase
      return {t[TAG_W-1:0], re[WIDTH-1:0], im[WIDTH-1:0]};
   endfunction

   initial begin
      int ex_re[4];
      int ex_im[4];
      int sent, got, saw_low;
      int ar, ai, br, bi;
      logic [W-1:0] e;

      ex_re = '{130, 70, 120, 80};
      ex_im = '{-30, -70, -80, -20};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00;
      a_re = '0; a_img = '0; b_re = '0; b_img = '0; tag_in = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b1; s_mode = 2'b00;
      s_a_re = '0; s_a_img = '0; s_b_re = '0; s_b_img = '0; s_tag_in = '0;

      // Reset state
      step();
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_x_re", $signed(x_re), 0);
      check("rst_x_img", $signed(x_img), 0);
      check("rst_tag", tag_out, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);

      // Four modes back to back, A=(100,-50) B=(30,20), tags 1..4, latency 2
      for (int c = 0; c < 6; c++) begin
         if (c < 4) drive(2'(c), 100, -50, 30, 20, 4'(c + 1));
         else       in_valid = 1'b0;
         if (c < 2) check("lat_not_yet", out_valid, 0);
         if (c >= 2) begin
            check("lat_valid", out_valid, 1);
            check("lat_re", $signed(x_re), ex_re[c-2]);
            check("lat_im", $signed(x_img), ex_im[c-2]);
            check("lat_tag", tag_out, c - 1);
         end
         step();
      end
      check("lat_drained", out_valid, 0);

      // Backpressure: 6 samples, out_ready low on cycles 3..6 after first accept
      sent = 0; got = 0; saw_low = 0;
      for (int k = 0; k < 40 && got < 6; k++) begin
         out_ready = !(k >= 3 && k <= 6);
         ar = sent * 10 + 5; ai = -sent; br = sent + 1; bi = 2 * sent;
         if (sent < 6) drive(2'(sent % 4), ar, ai, br, bi, 4'(sent + 5));
         else          in_valid = 1'b0;
         #1;
         if (!in_ready) saw_low = 1;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("bp_spurious", out_valid, 0);
            end else begin
               e = exp_q[0];
               check("bp_tag", tag_out, e[W-1 -: TAG_W]);
               check("bp_re", $signed(x_re), $signed(e[2*WIDTH-1 -: WIDTH]));
               check("bp_im", $signed(x_img), $signed(e[WIDTH-1:0]));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  got++;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(sent % 4, ar, ai, br, bi, sent + 5));
            sent++;
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_count", got, 6);
      check("bp_q_empty", exp_q.size(), 0);
      check("bp_in_ready_low", saw_low, 1);
      step();
      step();

      // Overflow: 32767 + 1
      drive(2'b00, 32767, 0, 1, 0, 4'hA);
      step();
      in_valid = 1'b0;
      step();
      check("wrap_valid", out_valid, 1);
      check("wrap_tag", tag_out, 4'hA);
`ifdef CPLX_ADDSUB_SAT_EN
      check("wrap_re", $signed(x_re), 32767);
      check("wrap_ovf", ovf, 1);
`else
      check("wrap_re", $signed(x_re), -32768);
      check("wrap_ovf", ovf, 0);
`endif
      check("wrap_im", $signed(x_img), 0);

      // A=(32767,-32768) - B=(1,1): imag component overflows
      drive(2'b01, 32767, -32768, 1, 1, 4'hB);
      step();
      in_valid = 1'b0;
      step();
      check("sat_re", $signed(x_re), 32766);
`ifdef CPLX_ADDSUB_SAT_EN
      check("sat_im", $signed(x_img), -32768);
      check("sat_ovf", ovf, 1);
`else
      check("sat_im", $signed(x_img), 32767);
      check("sat_ovf", ovf, 0);
`endif

      // Clean sample afterwards: ovf remains sticky when saturation is built in
      drive(2'b00, 1, 2, 3, 4, 4'hC);
      step();
      in_valid = 1'b0;
      step();
      check("clean_re", $signed(x_re), 4);
      check("clean_im", $signed(x_img), 6);
`ifdef CPLX_ADDSUB_SAT_EN
      check("clean_ovf", ovf, 1);
`else
      check("clean_ovf", ovf, 0);
`endif

      // SCALE=1 instance: halving with floor, extremes never overflow
      drive_s(2'b00, 32767, -32768, 32767, -32768, 4'h3);
      step();
      drive_s(2'b00, 3, -3, 0, 0, 4'h4);
      step();
      s_in_valid = 1'b0;
      check("scale1_valid", s_out_valid, 1);
      check("scale1_re", $signed(s_x_re), 32767);
      check("scale1_im", $signed(s_x_img), -32768);
      check("scale1_ovf", s_ovf, 0);
      step();
      check("scale2_re", $signed(s_x_re), 1);
      check("scale2_im", $signed(s_x_img), -2);
      check("scale2_tag", s_tag_out, 4'h4);
      check("scale2_ovf", s_ovf, 0);
      step();

      // Reset while samples are in flight
      drive(2'b00, 5, 5, 5, 5, 4'h1);
      step();
      drive(2'b01, 7, 7, 7, 7, 4'h2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_x_re", $signed(x_re), 0);
      check("midrst_x_img", $signed(x_img), 0);
      check("midrst_tag", tag_out, 0);
      check("midrst_ovf", ovf, 0);
      check("midrst_in_ready", in_ready, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("midrst_no_out", out_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
